// File: rtl/fixed_point_alu_sequencer.sv
// Multi-cycle fixed-point (scale 100) add/sub/mul/div engine with a shared 64-by-32 restoring divider.
// Optional result saturation with an overflow flag is enabled by defining ALU_SATURATE_EN.
module fixed_point_alu_sequencer #(
    parameter int FIXED_POINT_MULTIPLIER = 100,
    parameter int DIV_ITERATIONS         = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  alu_op,
    input  logic [31:0] operandF,
    input  logic [31:0] operandS,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        overflow,
    output logic [1:0]  state_dbg
);

    // Handshake: start is sampled only in IDLE; busy is high from the accepting edge until the
    // edge that raises done; done is a one-cycle pulse during which result and flags are valid.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int CW = $clog2(DIV_ITERATIONS) + 1;

    logic [1:0]    state;
    logic [1:0]    op_q;
    logic [31:0]   f_q;
    logic [31:0]   s_q;
    logic [63:0]   n_q;
    logic [31:0]   d_q;
    logic [32:0]   rem_q;
    logic [CW-1:0] cnt_q;
    logic          sign_q;

    logic [31:0] abs_f;
    logic [31:0] abs_s;
    logic [63:0] prod;
    logic [63:0] abs_prod;
    logic [32:0] rem_shift;
    logic        q_bit;
    logic [32:0] rem_next;
    logic [31:0] fin_val;
    logic [31:0] addsub_res;
    logic [31:0] fin_res;

    assign state_dbg = state;

    assign abs_f    = f_q[31] ? (~f_q + 32'd1) : f_q;
    assign abs_s    = s_q[31] ? (~s_q + 32'd1) : s_q;
    assign prod     = {{32{f_q[31]}}, f_q} * {{32{s_q[31]}}, s_q};
    assign abs_prod = prod[63] ? (~prod + 64'd1) : prod;

    // The quotient bits shift into the bottom of n_q as the dividend bits leave the top.
    assign rem_shift = (rem_q << 1) | {32'd0, n_q[63]};
    assign q_bit     = rem_shift >= {1'b0, d_q};
    assign rem_next  = q_bit ? (rem_shift - {1'b0, d_q}) : rem_shift;
    assign fin_val   = sign_q ? (~n_q[31:0] + 32'd1) : n_q[31:0];

`ifdef ALU_SATURATE_EN
    logic [32:0] sum33;
    logic        addsub_clamp;
    logic        fin_clamp;

    assign sum33 = op_q[0] ? ({f_q[31], f_q} - {s_q[31], s_q})
                           : ({f_q[31], f_q} + {s_q[31], s_q});
    assign addsub_clamp = sum33[32] ^ sum33[31];
    assign addsub_res   = addsub_clamp ? (sum33[32] ? 32'h8000_0000 : 32'h7fff_ffff) : sum33[31:0];
    assign fin_clamp    = sign_q ? (n_q > 64'h0000_0000_8000_0000) : (n_q > 64'h0000_0000_7fff_ffff);
    assign fin_res      = fin_clamp ? (sign_q ? 32'h8000_0000 : 32'h7fff_ffff) : fin_val;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (state == S_IDLE && start) begin
            overflow <= 1'b0;
        end else if (state == S_PREP && !op_q[1]) begin
            overflow <= addsub_clamp;
        end else if (state == S_FIN) begin
            overflow <= fin_clamp;
        end
    end
`else
    assign addsub_res = op_q[0] ? (f_q - s_q) : (f_q + s_q);
    assign fin_res    = fin_val;
    assign overflow   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= 2'd0;
            f_q         <= 32'd0;
            s_q         <= 32'd0;
            n_q         <= 64'd0;
            d_q         <= 32'd0;
            rem_q       <= 33'd0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= alu_op;
                        f_q         <= operandF;
                        s_q         <= operandS;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (!op_q[1]) begin
                        result <= addsub_res;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else if (op_q == 2'd3 && s_q == 32'd0) begin
                        result      <= 32'd0;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        // Multiply divides |F*S| by the scale; divide scales |F| up and divides by |S|.
                        if (op_q == 2'd2) begin
                            n_q <= abs_prod;
                            d_q <= 32'(FIXED_POINT_MULTIPLIER);
                        end else begin
                            n_q <= {32'd0, abs_f} * 64'(FIXED_POINT_MULTIPLIER);
                            d_q <= abs_s;
                        end
                        sign_q <= f_q[31] ^ s_q[31];
                        rem_q  <= 33'd0;
                        cnt_q  <= '0;
                        state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_next;
                    n_q   <= {n_q[62:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DIV_ITERATIONS - 1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    result <= fin_res;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_alu_sequencer.sv
// Scoreboard bench for fixed_point_alu_sequencer: a reference model predicts each result and its
// done cycle when stimulus is driven; a monitor pops and compares on every done pulse.
module tb_fixed_point_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  alu_op;
    logic [31:0] operandF;
    logic [31:0] operandS;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;
    logic        overflow;
    logic [1:0]  state_dbg;

    fixed_point_alu_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .alu_op      (alu_op),
        .operandF    (operandF),
        .operandS    (operandS),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Packed as {result[31:0], div_by_zero, overflow}.
    function automatic logic [33:0] model(input logic [1:0] op, input int f, input int s);
        longint lf = f;
        longint ls = s;
        longint r  = 0;
        logic   dz = 1'b0;
        logic   ov = 1'b0;
        logic [31:0] res;
        case (op)
            2'd0: r = lf + ls;
            2'd1: r = lf - ls;
            2'd2: r = (lf * ls) / 100;
            default: begin
                if (ls == 0) dz = 1'b1;
                else r = (lf * 100) / ls;
            end
        endcase
`ifdef ALU_SATURATE_EN
        if (r > 64'sd2147483647) begin r = 64'sd2147483647; ov = 1'b1; end
        if (r < -64'sd2147483648) begin r = -64'sd2147483648; ov = 1'b1; end
`endif
        res = r[31:0];
        return {res, dz, ov};
    endfunction

    function automatic int latency(input logic [1:0] op, input int s);
        if (op < 2'd2 || (op == 2'd3 && s == 0)) return 1;
        return 2 + 64;
    endfunction

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int          exp_cyc_q[$];
    int          done_count = 0;
    logic [31:0] prev_result = 32'd0;
    logic [33:0] mon_e;
    int          mon_c;

    always @(negedge clock) begin
        if (!reset && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("result",      64'(result),      64'(mon_e[33:2]));
                check("div_by_zero", 64'(div_by_zero), 64'(mon_e[1]));
                check("overflow",    64'(overflow),    64'(mon_e[0]));
                check("done_cycle",  64'(cyc),         64'(mon_c));
                check("busy_fall",   64'(busy),        64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic launch(input logic [1:0] op, input int f, input int s, output int k);
        logic [33:0] e;
        alu_op   = op;
        operandF = f;
        operandS = s;
        start    = 1'b1;
        tick();
        k     = cyc;
        start = 1'b0;
        check("busy_rise",   64'(busy),        64'd1);
        check("dbz_cleared", 64'(div_by_zero), 64'd0);
        if (latency(op, s) > 1) check("result_kept", 64'(result), 64'(prev_result));
        e = model(op, f, s);
        exp_q.push_back(e);
        exp_cyc_q.push_back(k + latency(op, s));
        prev_result = e[33:2];
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 200 && done_count == base; i++) tick();
        check("done_seen", 64'(done_count != base), 64'd1);
    endtask

    task automatic run(input logic [1:0] op, input int f, input int s);
        int k;
        int base;
        base = done_count;
        launch(op, f, s, k);
        wait_done(base);
        tick();
        tick();
        check("result_held", 64'(result), 64'(prev_result));
        check("busy_idle",   64'(busy),   64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int base;
        int c;
        logic [1:0] rop;
        int rf;
        int rs;

        reset    = 1'b1;
        start    = 1'b0;
        alu_op   = 2'd0;
        operandF = 32'd0;
        operandS = 32'd0;
        tick();
        tick();
        check("rst_busy",  64'(busy),        64'd0);
        check("rst_done",  64'(done),        64'd0);
        check("rst_result",64'(result),      64'd0);
        check("rst_dbz",   64'(div_by_zero), 64'd0);
        check("rst_ovf",   64'(overflow),    64'd0);
        check("rst_state", 64'(state_dbg),   64'd0);
        reset = 1'b0;
        tick();

        // Directed arithmetic cases
        run(2'd0, 150, 250);
        run(2'd1, 150, 250);
        run(2'd2, 250, -300);
        run(2'd2, 333, -50);
        run(2'd3, 100, 300);
        run(2'd3, -700, 200);
        run(2'd3, 500, 0);
        run(2'd0, 150, 250);
        run(2'd0, 2147483600, 100);
        run(2'd1, -2147483600, 100);
        run(2'd3, 2147483647, 1);
        run(2'd3, -2147483647, 1);
        run(2'd2, 32'h8000_0000, 32'h8000_0000);
        run(2'd3, 32'h8000_0000, 32'h8000_0000);

        // Second start during a divide is ignored
        base = done_count;
        launch(2'd3, 100, 300, k);
        while (cyc < k + 9) tick();
        alu_op   = 2'd0;
        operandF = 7;
        operandS = 9;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_done(base);
        for (int i = 0; i < 10; i++) tick();
        check("single_done", 64'(done_count - base), 64'd1);

        // Reset in the middle of a divide discards the operation
        launch(2'd3, -700, 200, k);
        while (cyc < k + 29) tick();
        reset = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        prev_result = 32'd0;
        tick();
        check("midrst_busy",   64'(busy),      64'd0);
        check("midrst_result", 64'(result),    64'd0);
        check("midrst_done",   64'(done),      64'd0);
        check("midrst_state",  64'(state_dbg), 64'd0);
        reset = 1'b0;
        base  = done_count;
        for (int i = 0; i < 80; i++) tick();
        check("midrst_no_done", 64'(done_count - base), 64'd0);

        // start held high: relaunches on every IDLE cycle, including the done cycle
        c        = cyc;
        alu_op   = 2'd1;
        operandF = 1000;
        operandS = 1234;
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(2'd1, 1000, 1234));
            exp_cyc_q.push_back(c + 2 + 2 * i);
        end
        prev_result = model(2'd1, 1000, 1234) >> 2;
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        tick();
        check("held_start_drained", 64'(exp_q.size()), 64'd0);

        // Random operations
        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(3));
            rf  = int'($urandom_range(200000)) - 100000;
            rs  = int'($urandom_range(4000)) - 2000;
            run(rop, rf, rs);
        end

        for (int i = 0; i < 5; i++) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
